// File: rtl/iu_branch_seq_if.sv
// ---------------------------------------------------------------------------
// iu_branch_seq_if
// Purpose : bundles the flags, retire/branch, redirect and PC-sequencing
//           signals between the branch sequencer and its surroundings.
// Signals :
//   flags_valid/flags_in            cc update from IUAdder ({n,z,v,c})
//   step                            instruction at pc retires this cycle
//   br_valid/br_cond/br_annul/
//   br_target                       Bicc qualifier, cond field, a bit, target
//   redirect_valid/redirect_pc      trap/jump redirect
//   icc, pc, npc                    committed cc and program counters
//   annul_cur                       instruction at pc is annulled
//   taken, misalign                 one-cycle registered event pulses
// Modports: master = producer/fetch side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface iu_branch_seq_if;
    logic        flags_valid;
    logic [3:0]  flags_in;
    logic        step;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic        br_annul;
    logic [31:0] br_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  icc;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        annul_cur;
    logic        taken;
    logic        misalign;

    modport master (
        output flags_valid, flags_in, step, br_valid, br_cond, br_annul,
               br_target, redirect_valid, redirect_pc,
        input  icc, pc, npc, annul_cur, taken, misalign
    );

    modport slave (
        input  flags_valid, flags_in, step, br_valid, br_cond, br_annul,
               br_target, redirect_valid, redirect_pc,
        output icc, pc, npc, annul_cur, taken, misalign
    );
endinterface

// File: rtl/iu_branch_seq.sv
// ---------------------------------------------------------------------------
// iu_branch_seq
// Purpose : holds the SPARC integer condition codes committed by cc-setting
//           ALU ops, evaluates Bicc conditions against them (with same-cycle
//           forwarding of a fresh cc update) and sequences pc/npc with
//           delayed-branch and annul semantics.
// Ports   :
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    iu_branch_seq_if.slave (flags in, retire/branch/redirect in,
//          icc/pc/npc/annul_cur/taken/misalign out)
// Parameter: RESET_PC - pc after reset; npc resets to RESET_PC+4.
// ---------------------------------------------------------------------------
module iu_branch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    iu_branch_seq_if.slave bus
);

    typedef enum logic {
        RUN   = 1'b0,
        ANNUL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [3:0]  icc_q, icc_d;
    logic        taken_q, taken_d;
    logic        misalign_q, misalign_d;

    logic [3:0]  eff_cc;
    logic [31:0] npc_plus4;
    logic        cond_hit;

    // Bicc condition: the low three bits select a base test, bit 3 inverts
    // it (1000 "always" is the inverse of 0000 "never", and so on).
    function automatic logic bicc_true(input logic [3:0] cond, input logic [3:0] cc);
        logic n, z, v, c, base;
        n = cc[3];
        z = cc[2];
        v = cc[1];
        c = cc[0];
        case (cond[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = z;
            3'd2:    base = z | (n ^ v);
            3'd3:    base = n ^ v;
            3'd4:    base = c | z;
            3'd5:    base = c;
            3'd6:    base = n;
            default: base = v;
        endcase
        return cond[3] ? ~base : base;
    endfunction

    // A cc update in the same cycle as the branch is forwarded.
    assign eff_cc    = bus.flags_valid ? bus.flags_in : icc_q;
    assign npc_plus4 = npc_q + 32'd4;
    assign cond_hit  = bicc_true(bus.br_cond, eff_cc);

    always_comb begin
        pc_d       = pc_q;
        npc_d      = npc_q;
        state_d    = state_q;
        taken_d    = 1'b0;
        misalign_d = 1'b0;
        // The annulled instruction never commits its cc update.
        icc_d      = (bus.flags_valid && state_q == RUN) ? bus.flags_in : icc_q;

        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc;
            npc_d      = bus.redirect_pc + 32'd4;
            state_d    = RUN;
            misalign_d = |bus.redirect_pc[1:0];
        end else if (bus.step) begin
            pc_d    = npc_q;
            npc_d   = npc_plus4;
            state_d = RUN;
            if (state_q == RUN && bus.br_valid) begin
                if (cond_hit) begin
                    // A misaligned target is reported and the branch is
                    // dropped: sequencing continues fall-through.
                    if (|bus.br_target[1:0]) begin
                        misalign_d = 1'b1;
                    end else begin
                        npc_d   = bus.br_target;
                        taken_d = 1'b1;
                    end
                    // Only BA,a annuls the delay slot of a taken branch.
                    state_d = (bus.br_annul && bus.br_cond == 4'b1000) ? ANNUL : RUN;
                end else begin
                    state_d = bus.br_annul ? ANNUL : RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            npc_q      <= RESET_PC + 32'd4;
            icc_q      <= 4'b0000;
            taken_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            icc_q      <= icc_d;
            taken_q    <= taken_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.icc       = icc_q;
    assign bus.pc        = pc_q;
    assign bus.npc       = npc_q;
    assign bus.annul_cur = (state_q == ANNUL);
    assign bus.taken     = taken_q;
    assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_iu_branch_seq.sv
// ---------------------------------------------------------------------------
// tb_iu_branch_seq
// Directed and randomized stimulus; each clocked transaction pushes the
// reference model's expected architectural state into a queue, and a
// separate monitor pops and compares it against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_iu_branch_seq;

    logic clk;
    logic rst_n;

    iu_branch_seq_if bus ();

    iu_branch_seq #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [3:0]  icc;
        logic        annul;
        logic        taken;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   txn;

    // Reference architectural state
    logic [31:0] m_pc, m_npc;
    logic [3:0]  m_icc;
    logic        m_annul, m_taken, m_mis;

    // Bicc truth table written out entry by entry.
    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] cc);
        logic n, z, v, c;
        n = cc[3]; z = cc[2]; v = cc[1]; c = cc[0];
        case (cond)
            4'b1000: return 1'b1;
            4'b0000: return 1'b0;
            4'b1001: return !z;
            4'b0001: return z;
            4'b1010: return !(z || (n != v));
            4'b0010: return z || (n != v);
            4'b1011: return n == v;
            4'b0011: return n != v;
            4'b1100: return !(c || z);
            4'b0100: return c || z;
            4'b1101: return !c;
            4'b0101: return c;
            4'b1110: return !n;
            4'b0110: return n;
            4'b1111: return !v;
            default: return v;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_npc = 32'h4; m_icc = 4'h0;
        m_annul = 1'b0; m_taken = 1'b0; m_mis = 1'b0;
    endtask

    // Apply one cycle of inputs, let the edge happen, then advance the model.
    task automatic drive(input logic fv, input logic [3:0] fi, input logic st,
                         input logic bv, input logic [3:0] bc, input logic ba,
                         input logic [31:0] bt, input logic rv, input logic [31:0] rp);
        logic [3:0] eff;
        logic       was_annul;
        exp_t       e;
        bus.flags_valid = fv; bus.flags_in = fi; bus.step = st;
        bus.br_valid = bv; bus.br_cond = bc; bus.br_annul = ba; bus.br_target = bt;
        bus.redirect_valid = rv; bus.redirect_pc = rp;
        @(posedge clk);
        #1;
        eff = fv ? fi : m_icc;
        was_annul = m_annul;
        m_taken = 1'b0;
        m_mis = 1'b0;
        if (rv) begin
            m_pc = rp; m_npc = rp + 32'd4; m_annul = 1'b0;
            m_mis = (rp % 4) != 0;
        end else if (st) begin
            m_pc = m_npc;
            if (was_annul) begin
                m_npc = m_npc + 32'd4; m_annul = 1'b0;
            end else if (bv && ref_cond(bc, eff)) begin
                if ((bt % 4) != 0) begin
                    m_mis = 1'b1; m_npc = m_npc + 32'd4;
                end else begin
                    m_npc = bt; m_taken = 1'b1;
                end
                m_annul = ba && (bc == 4'b1000);
            end else begin
                m_npc = m_npc + 32'd4;
                m_annul = bv && ba;
            end
        end
        if (fv && !was_annul) m_icc = fi;
        e.pc = m_pc; e.npc = m_npc; e.icc = m_icc;
        e.annul = m_annul; e.taken = m_taken; e.mis = m_mis;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 4'h0, 0, 0, 4'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic do_step();
        drive(0, 4'h0, 1, 0, 4'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic set_idle_inputs();
        bus.flags_valid = 0; bus.flags_in = 0; bus.step = 0; bus.br_valid = 0;
        bus.br_cond = 0; bus.br_annul = 0; bus.br_target = 0;
        bus.redirect_valid = 0; bus.redirect_pc = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, bus.pc, 32'h0);
        chk({tag, "_npc"}, bus.npc, 32'h4);
        chk({tag, "_icc"}, {28'h0, bus.icc}, 32'h0);
        chk({tag, "_annul"}, {31'h0, bus.annul_cur}, 32'h0);
        chk({tag, "_taken"}, {31'h0, bus.taken}, 32'h0);
        chk({tag, "_mis"}, {31'h0, bus.misalign}, 32'h0);
    endtask

    // Monitor: every transaction's expected state is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                chk("pc", bus.pc, e.pc);
                chk("npc", bus.npc, e.npc);
                chk("icc", {28'h0, bus.icc}, {28'h0, e.icc});
                chk("annul_cur", {31'h0, bus.annul_cur}, {31'h0, e.annul});
                chk("taken", {31'h0, bus.taken}, {31'h0, e.taken});
                chk("misalign", {31'h0, bus.misalign}, {31'h0, e.mis});
                if (txn <= 40)
                    $display("txn %0d: pc=%h npc=%h icc=%b annul=%b taken=%b mis=%b",
                             txn, bus.pc, bus.npc, bus.icc, bus.annul_cur, bus.taken, bus.misalign);
            end
        end
    end

    initial begin
        logic [31:0] tgt, rp;
        int          r;
        checks = 0; failures = 0; txn = 0;
        set_idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch
        repeat (3) do_step();
        // Forwarding: BE at pc=C with same-cycle z=1 update
        drive(1, 4'b0100, 1, 1, 4'b0001, 0, 32'h100, 0, 32'h0);
        // Redirect to 8, clear z, untaken BE,a annuls delay slot
        drive(1, 4'b0000, 0, 0, 4'h0, 0, 32'h0, 1, 32'h8);
        drive(0, 4'h0, 1, 1, 4'b0001, 1, 32'h80, 0, 32'h0);
        // Squashed step: flags_valid must be ignored
        drive(1, 4'b1111, 1, 1, 4'b1000, 0, 32'h300, 0, 32'h0);
        // BA,a from pc=0 to 0x40
        drive(0, 4'h0, 0, 0, 4'h0, 0, 32'h0, 1, 32'h0);
        drive(0, 4'h0, 1, 1, 4'b1000, 1, 32'h40, 0, 32'h0);
        do_step();
        // BA a=0: delay slot not annulled
        drive(0, 4'h0, 1, 1, 4'b1000, 0, 32'h80, 0, 32'h0);
        do_step();
        // Redirect while ANNUL
        drive(0, 4'h0, 1, 1, 4'b0000, 1, 32'h0, 0, 32'h0);
        drive(0, 4'h0, 0, 0, 4'h0, 0, 32'h0, 1, 32'h200);
        // Misaligned target and misaligned redirect
        drive(0, 4'h0, 1, 1, 4'b1000, 0, 32'h102, 0, 32'h0);
        drive(0, 4'h0, 0, 0, 4'h0, 0, 32'h0, 1, 32'h301);
        // Wrap of npc+4
        drive(0, 4'h0, 0, 0, 4'h0, 0, 32'h0, 1, 32'hFFFF_FFF8);
        repeat (3) do_step();

        // Async reset while in ANNUL
        drive(0, 4'h0, 0, 0, 4'h0, 0, 32'h0, 1, 32'h8);
        drive(1, 4'b0000, 1, 1, 4'b0001, 1, 32'h80, 0, 32'h0);
        @(negedge clk);
        #2;
        set_idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Full condition table: committed cc, then forwarded cc
        for (int cc = 0; cc < 16; cc++) begin
            for (int cd = 0; cd < 16; cd++) begin
                drive(1, cc[3:0], 0, 0, 4'h0, 0, 32'h0, 1, 32'h1000);
                drive(0, 4'h0, 1, 1, cd[3:0], 0, 32'h2000, 0, 32'h0);
                drive(1, cc[3:0], 1, 1, cd[3:0], 0, 32'h3000, 0, 32'h0);
            end
        end

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r   = $urandom_range(0, 99);
            tgt = {$urandom_range(0, 32'hFFFF), 16'h0} | {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            rp  = {$urandom, 2'b00} >> 0;
            rp  = rp & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rp[1:0] = 2'($urandom_range(1, 3));
            drive(($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), tgt,
                  (r < 5), rp);
        end

        idle();
        idle();
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
